// File: rtl/pcie_tx_arb.sv
// Two-requester TLP arbiter in front of a PCIe core transmit port (VC0).
// Gates each requester on TLP class and available credits, then streams its beats to the core.
module pcie_tx_arb #(
  parameter int MAX_BEATS = 136
) (
  input  logic        sys_clk_125,
  input  logic        rst,
  input  logic        dl_up,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  type0,
  input  logic [1:0]  type1,
  input  logic [7:0]  dcred0,
  input  logic [7:0]  dcred1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        end0,
  input  logic        end1,
  input  logic        tx_rdy_vc0,
  input  logic [8:0]  tx_ca_ph_vc0,
  input  logic [8:0]  tx_ca_nph_vc0,
  input  logic [8:0]  tx_ca_cplh_vc0,
  input  logic [12:0] tx_ca_pd_vc0,
  input  logic [12:0] tx_ca_npd_vc0,
  input  logic [12:0] tx_ca_cpld_vc0,
  output logic        gnt0,
  output logic        gnt1,
  output logic        tx_req_vc0,
  output logic [15:0] tx_data_vc0,
  output logic        tx_st_vc0,
  output logic        tx_end_vc0,
  output logic        tx_nlfy_vc0,
  output logic        busy,
  output logic        ovf_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester holds req (and its type/dcred) until its gnt falls.
  // While gnt is high one beat (data/end) is consumed on every rising clock edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [9:0] LIMIT = 10'(MAX_BEATS - 1);

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_owner, last_owner_nxt;
  logic [9:0]  cnt, cnt_nxt;

  logic [8:0]  hdr0, hdr1;
  logic [12:0] dat0, dat1;
  logic        elig0, elig1;
  logic        cur_end, abort;

  // Credit pool selection by TLP class; reserved class selects nothing.
  always_comb begin
    hdr0 = '0;
    dat0 = '0;
    case (type0)
      2'b00: begin hdr0 = tx_ca_ph_vc0;   dat0 = tx_ca_pd_vc0;   end
      2'b01: begin hdr0 = tx_ca_nph_vc0;  dat0 = tx_ca_npd_vc0;  end
      2'b10: begin hdr0 = tx_ca_cplh_vc0; dat0 = tx_ca_cpld_vc0; end
      default: begin hdr0 = '0; dat0 = '0; end
    endcase
  end

  always_comb begin
    hdr1 = '0;
    dat1 = '0;
    case (type1)
      2'b00: begin hdr1 = tx_ca_ph_vc0;   dat1 = tx_ca_pd_vc0;   end
      2'b01: begin hdr1 = tx_ca_nph_vc0;  dat1 = tx_ca_npd_vc0;  end
      2'b10: begin hdr1 = tx_ca_cplh_vc0; dat1 = tx_ca_cpld_vc0; end
      default: begin hdr1 = '0; dat1 = '0; end
    endcase
  end

  // A nonzero header field covers both "some credit" and "infinite" (bit 8).
  assign elig0 = req0 && (type0 != 2'b11) && (hdr0 != 9'd0) &&
                 (dat0[12] || (dat0 >= {5'd0, dcred0}));
  assign elig1 = req1 && (type1 != 2'b11) && (hdr1 != 9'd0) &&
                 (dat1[12] || (dat1 >= {5'd0, dcred1}));

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    tx_req_vc0     = 1'b0;
    tx_data_vc0    = '0;
    tx_st_vc0      = 1'b0;
    tx_end_vc0     = 1'b0;
    tx_nlfy_vc0    = 1'b0;
    ovf_err        = 1'b0;
    cur_end        = 1'b0;
    abort          = 1'b0;

    case (state)
      IDLE: begin
        if (dl_up && (elig0 || elig1)) begin
          state_nxt = REQ;
          owner_nxt = (elig0 && elig1) ? ~last_owner : elig1;
        end
      end

      REQ: begin
        tx_req_vc0 = 1'b1;
        if (!dl_up) begin
          state_nxt = IDLE;
        end else if (tx_rdy_vc0) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end
      end

      XFER: begin
        gnt0        = ~owner;
        gnt1        = owner;
        tx_data_vc0 = owner ? data1 : data0;
        cur_end     = owner ? end1 : end0;
        // A requester that runs past the beat limit gets its TLP nullified.
        abort       = (cnt == LIMIT) && !cur_end;
        tx_st_vc0   = (cnt == 10'd0);
        tx_end_vc0  = cur_end || abort;
        tx_nlfy_vc0 = abort;
        ovf_err     = abort;
        cnt_nxt     = cnt + 10'd1;
        if (cur_end || abort) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Directed bench for pcie_tx_arb, built with an 8-beat limit so the limit paths are short.
module tb_pcie_tx_arb;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_up;
  logic        req0, req1;
  logic [1:0]  type0, type1;
  logic [7:0]  dcred0, dcred1;
  logic [15:0] data0, data1;
  logic        end0, end1;
  logic        tx_rdy;
  logic [8:0]  ph, nph, cplh;
  logic [12:0] pd, npd, cpld;
  logic        gnt0, gnt1, tx_req;
  logic [15:0] tx_data;
  logic        tx_st, tx_end, tx_nlfy, busy, ovf_err;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcie_tx_arb #(.MAX_BEATS(MAXB)) dut (
    .sys_clk_125    (clk),
    .rst            (rst),
    .dl_up          (dl_up),
    .req0           (req0),
    .req1           (req1),
    .type0          (type0),
    .type1          (type1),
    .dcred0         (dcred0),
    .dcred1         (dcred1),
    .data0          (data0),
    .data1          (data1),
    .end0           (end0),
    .end1           (end1),
    .tx_rdy_vc0     (tx_rdy),
    .tx_ca_ph_vc0   (ph),
    .tx_ca_nph_vc0  (nph),
    .tx_ca_cplh_vc0 (cplh),
    .tx_ca_pd_vc0   (pd),
    .tx_ca_npd_vc0  (npd),
    .tx_ca_cpld_vc0 (cpld),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .tx_req_vc0     (tx_req),
    .tx_data_vc0    (tx_data),
    .tx_st_vc0      (tx_st),
    .tx_end_vc0     (tx_end),
    .tx_nlfy_vc0    (tx_nlfy),
    .busy           (busy),
    .ovf_err        (ovf_err),
    .state_dbg      (state_dbg)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n beats from requester 'who' starting at an XFER cycle, then checks the IDLE gap.
  task automatic xfer_beats(input int who, input int n, input bit give_end,
                            input logic [15:0] base, input bit drop);
    logic [15:0] exp_d;
    bit          last, ab;
    for (int b = 0; b < n; b++) begin
      exp_d = base + 16'(b);
      last  = give_end && (b == n - 1);
      ab    = !give_end && (b == MAXB - 1);
      if (who == 0) begin
        data0 = exp_d; end0 = last; data1 = 16'hdead; end1 = 1'b0;
      end else begin
        data1 = exp_d; end1 = last; data0 = 16'hbeef; end0 = 1'b0;
      end
      @(negedge clk);
      total++;
      if (gnt0 !== (who == 0) || gnt1 !== (who == 1)) begin
        bad++;
        $display("FAIL gnt beat %0d: gnt0=%b gnt1=%b required owner %0d", b, gnt0, gnt1, who);
      end
      total++;
      if (tx_data !== exp_d) begin
        bad++;
        $display("FAIL data beat %0d: got %h required %h", b, tx_data, exp_d);
      end
      total++;
      if ({tx_st, tx_end, tx_nlfy, ovf_err, tx_req} !== {b == 0, last || ab, ab, ab, 1'b0}) begin
        bad++;
        $display("FAIL strobes beat %0d: st/end/nlfy/ovf/req=%b%b%b%b%b required %b%b%b%b0",
                 b, tx_st, tx_end, tx_nlfy, ovf_err, tx_req, b == 0, last || ab, ab, ab);
      end
      tick();
    end
    end0 = 1'b0; end1 = 1'b0; data0 = '0; data1 = '0;
    if (drop) begin
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || tx_data !== 16'h0 ||
        ovf_err !== 1'b0 || tx_end !== 1'b0) begin
      bad++;
      $display("FAIL idle_gap: gnt=%b%b busy=%b data=%h ovf=%b end=%b required all 0",
               gnt0, gnt1, busy, tx_data, ovf_err, tx_end);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dl_up = 1'b0; req0 = 1'b0; req1 = 1'b0;
    type0 = 2'b00; type1 = 2'b00; dcred0 = '0; dcred1 = '0;
    data0 = '0; data1 = '0; end0 = 1'b0; end1 = 1'b0; tx_rdy = 1'b0;
    ph = '0; nph = '0; cplh = '0; pd = '0; npd = '0; cpld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, tx_req, tx_st, tx_end, tx_nlfy, busy, ovf_err} !== 8'h00 ||
        tx_data !== 16'h0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset: outs=%b data=%h state=%0d required 0", {gnt0, gnt1, tx_req, tx_st,
               tx_end, tx_nlfy, busy, ovf_err}, tx_data, state_dbg);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req0 = 1'b1; type0 = 2'b00; dcred0 = 8'd4; ph = 9'd1; pd = 13'd4;
    dl_up = 1'b1; tx_rdy = 1'b0;
    @(negedge clk);
    total++;
    if (tx_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: tx_req=%b busy=%b required 0 0", tx_req, busy);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      tx_rdy = (c == 2);
      @(negedge clk);
      total++;
      if (tx_req !== 1'b1 || gnt0 !== 1'b0 || state_dbg !== 2'd1) begin
        bad++;
        $display("FAIL basic_req cycle %0d: tx_req=%b gnt0=%b state=%0d required 1 0 1",
                 c, tx_req, gnt0, state_dbg);
      end
      tick();
    end
    tx_rdy = 1'b0;
    // 8 beats with end on the limit beat: a normal end, no nullify.
    xfer_beats(0, 8, 1'b1, 16'h1000, 1'b1);
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; type0 = 2'b00; type1 = 2'b00;
    dcred0 = 8'd1; dcred1 = 8'd1; ph = 9'd1; pd = 13'd4; tx_rdy = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_reset: busy=%b required 0", busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) req0 = 1'b0;
      @(negedge clk);
      total++;
      if (tx_req !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_req %0d: tx_req=%b busy=%b required 1 1", k, tx_req, busy);
      end
      tick();
      xfer_beats(k % 2, 2, 1'b1, 16'h2000 + 16'(k * 16), k == 3);
    end
  endtask

  task automatic test_credit();
    tx_rdy = 1'b1;
    // Reserved class and zero header credit are never eligible.
    for (int v = 0; v < 2; v++) begin
      req0 = 1'b1; type0 = (v == 0) ? 2'b11 : 2'b00; dcred0 = 8'd0;
      ph = (v == 0) ? 9'h100 : 9'd0; nph = 9'h100; cplh = 9'h100;
      pd = 13'h1000; npd = 13'h1000; cpld = 13'h1000;
      tick();
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx_req !== 1'b0) begin
        bad++;
        $display("FAIL inelig %0d: busy=%b tx_req=%b required 0 0", v, busy, tx_req);
      end
    end
    req0 = 1'b0;
    tick();
    req0 = 1'b1; type0 = 2'b00; dcred0 = 8'd4; ph = 9'd1; pd = 13'd3;
    req1 = 1'b1; type1 = 2'b10; dcred1 = 8'd2; cplh = 9'd1; cpld = 13'd2;
    tick();
    @(negedge clk);
    total++;
    if (tx_req !== 1'b1) begin
      bad++;
      $display("FAIL credit_req: tx_req=%b required 1", tx_req);
    end
    tick();
    xfer_beats(1, 3, 1'b1, 16'h3000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx_req !== 1'b0) begin
        bad++;
        $display("FAIL credit_wait %0d: busy=%b tx_req=%b required 0 0", c, busy, tx_req);
      end
    end
    pd = 13'h1000;
    tick();
    @(negedge clk);
    total++;
    if (tx_req !== 1'b1) begin
      bad++;
      $display("FAIL credit_inf: tx_req=%b required 1", tx_req);
    end
    tick();
    xfer_beats(0, 1, 1'b1, 16'h4000, 1'b1);
  endtask

  task automatic test_limit();
    req0 = 1'b1; type0 = 2'b00; dcred0 = 8'd1; ph = 9'd1; pd = 13'd4; tx_rdy = 1'b1;
    tick();
    pd = 13'd0;
    @(negedge clk);
    total++;
    if (tx_req !== 1'b1) begin
      bad++;
      $display("FAIL limit_req: tx_req=%b required 1", tx_req);
    end
    tick();
    xfer_beats(0, MAXB, 1'b0, 16'h5000, 1'b1);
    pd = 13'd4;
  endtask

  task automatic test_dl_down();
    req0 = 1'b1; type0 = 2'b00; dcred0 = 8'd1; ph = 9'd1; pd = 13'd4;
    dl_up = 1'b1; tx_rdy = 1'b0;
    tick();
    dl_up = 1'b0;
    @(negedge clk);
    total++;
    if (tx_req !== 1'b1) begin
      bad++;
      $display("FAIL dl_req: tx_req=%b required 1", tx_req);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      total++;
      if (tx_req !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL dl_idle %0d: tx_req=%b gnt0=%b busy=%b required 0 0 0",
                 c, tx_req, gnt0, busy);
      end
    end
    dl_up = 1'b1; tx_rdy = 1'b1;
    tick();
    tick();
    dl_up = 1'b0;
    xfer_beats(0, 3, 1'b1, 16'h6000, 1'b0);
    dl_up = 1'b1;
    tick();
    tick();
    data0 = 16'h7000;
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b1 || tx_st !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: gnt0=%b st=%b required 1 1", gnt0, tx_st);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1, tx_req, tx_st, tx_end, tx_nlfy, busy, ovf_err} !== 8'h00 ||
        tx_data !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid: outs=%b data=%h required 0", {gnt0, gnt1, tx_req, tx_st,
               tx_end, tx_nlfy, busy, ovf_err}, tx_data);
    end
    tick();
    rst = 1'b0; req0 = 1'b0; data0 = '0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || tx_end !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: busy=%b end=%b required 0 0", busy, tx_end);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_credit();
    test_limit();
    test_dl_down();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
